// File: rtl/calendar_timer.sv
// Calendar time base: second..year fields advanced by one prescaled tick,
// with preset load, up/down counting, sticky year-wrap flag and h:m:s alarm.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, stop           - run control levels (stop wins)
//   load, ld_*            - preset all six fields (saturated to field max)
//   dir                   - 0 = count up, 1 = count down
//   alarm_en, al_*        - alarm enable and h:m:s alarm time
//   year..second          - registered time fields
//   running, sec_tick     - run state, one-cycle pulse on field update
//   wrapped, alarm        - sticky year wrap, one-cycle alarm pulse
module calendar_timer #(
  parameter int unsigned TICK_DIV       = 50,
  parameter int unsigned DAYS_PER_MONTH = 30,
  parameter int unsigned MONTHS         = 12,
  parameter int unsigned YEAR_MAX       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic       dir,
  input  logic [7:0] ld_year,
  input  logic [7:0] ld_month,
  input  logic [7:0] ld_day,
  input  logic [7:0] ld_hour,
  input  logic [7:0] ld_minute,
  input  logic [7:0] ld_second,
  input  logic       alarm_en,
  input  logic [7:0] al_hour,
  input  logic [7:0] al_minute,
  input  logic [7:0] al_second,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       running,
  output logic       sec_tick,
  output logic       wrapped,
  output logic       alarm
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] DAY_MAX  = 8'(DAYS_PER_MONTH - 1);
  localparam logic [7:0] MON_MAX  = 8'(MONTHS - 1);
  localparam logic [7:0] YR_MAX   = 8'(YEAR_MAX);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick_c;
  logic          alarm_pend;

  logic [8:0] s_r, m_r, h_r, d_r, mo_r, y_r;
  logic       c_min, c_hour, c_day, c_mon, c_year, yr_wrap;
  logic [7:0] sec_n, min_n, hour_n, day_n, mon_n, year_n;

  // One step of a field: returns {wrap, new value}, wrapping at max / 0.
  function automatic logic [8:0] bump(input logic [7:0] v, input logic [7:0] max,
                                      input logic dn);
    logic       w;
    logic [7:0] n;
    if (!dn) begin
      w = (v >= max);
      n = w ? 8'd0 : v + 8'd1;
    end else begin
      w = (v == 8'd0);
      n = w ? max : v - 8'd1;
    end
    return {w, n};
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v, input logic [7:0] max);
    return (v > max) ? max : v;
  endfunction

  // Run state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Run state next-state: stop dominates start
  always_comb begin
    state_nxt = state;
    if (stop)       state_nxt = IDLE;
    else if (start) state_nxt = RUN;
  end

  assign running = state[0];

  // Prescaler: counts only when already running; load restarts the interval
  always_comb begin
    presc_nxt = presc;
    tick_c    = 1'b0;
    if (load) begin
      presc_nxt = '0;
    end else if (state == RUN) begin
      if (presc == PW'(TICK_DIV - 1)) begin
        presc_nxt = '0;
        tick_c    = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  // Single-edge carry/borrow cascade from second up to year
  always_comb begin
    s_r  = bump(second, SEC_MAX,  dir);
    m_r  = bump(minute, MIN_MAX,  dir);
    h_r  = bump(hour,   HOUR_MAX, dir);
    d_r  = bump(day,    DAY_MAX,  dir);
    mo_r = bump(month,  MON_MAX,  dir);
    y_r  = bump(year,   YR_MAX,   dir);

    c_min   = tick_c & s_r[8];
    c_hour  = c_min  & m_r[8];
    c_day   = c_hour & h_r[8];
    c_mon   = c_day  & d_r[8];
    c_year  = c_mon  & mo_r[8];
    yr_wrap = c_year & y_r[8];

    sec_n  = tick_c ? s_r[7:0]  : second;
    min_n  = c_min  ? m_r[7:0]  : minute;
    hour_n = c_hour ? h_r[7:0]  : hour;
    day_n  = c_day  ? d_r[7:0]  : day;
    mon_n  = c_mon  ? mo_r[7:0] : month;
    year_n = c_year ? y_r[7:0]  : year;
  end

  // Field, flag and alarm registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      year       <= 8'd0;
      month      <= 8'd0;
      day        <= 8'd0;
      hour       <= 8'd0;
      minute     <= 8'd0;
      second     <= 8'd0;
      sec_tick   <= 1'b0;
      wrapped    <= 1'b0;
      alarm_pend <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      presc <= presc_nxt;
      // A match captured on the tick edge pulses one cycle later regardless of alarm_en
      alarm      <= alarm_pend;
      alarm_pend <= tick_c & alarm_en & (hour_n == al_hour) &
                    (min_n == al_minute) & (sec_n == al_second);
      sec_tick   <= tick_c;
      if (load) begin
        year    <= sat(ld_year,   YR_MAX);
        month   <= sat(ld_month,  MON_MAX);
        day     <= sat(ld_day,    DAY_MAX);
        hour    <= sat(ld_hour,   HOUR_MAX);
        minute  <= sat(ld_minute, MIN_MAX);
        second  <= sat(ld_second, SEC_MAX);
        wrapped <= 1'b0;
      end else begin
        year   <= year_n;
        month  <= mon_n;
        day    <= day_n;
        hour   <= hour_n;
        minute <= min_n;
        second <= sec_n;
        if (yr_wrap) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calendar_timer.sv
// Self-checking bench for calendar_timer (TICK_DIV = 4). Load vectors are
// table-driven; tick results come from a linear-seconds reference model via
// a scoreboard queue, popped when the DUT raises sec_tick.
module tb_calendar_timer;

  localparam int unsigned TD  = 4;
  localparam int unsigned DPM = 30;
  localparam int unsigned MO  = 12;
  localparam int unsigned YM  = 99;

  logic       clk = 1'b0;
  logic       reset, start, stop, load, dir, alarm_en;
  logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second;
  logic [7:0] al_hour, al_minute, al_second;
  logic [7:0] year, month, day, hour, minute, second;
  logic       running, sec_tick, wrapped, alarm;

  calendar_timer #(
    .TICK_DIV(TD), .DAYS_PER_MONTH(DPM), .MONTHS(MO), .YEAR_MAX(YM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load), .dir(dir),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day), .ld_hour(ld_hour),
    .ld_minute(ld_minute), .ld_second(ld_second), .alarm_en(alarm_en),
    .al_hour(al_hour), .al_minute(al_minute), .al_second(al_second),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .running(running), .sec_tick(sec_tick), .wrapped(wrapped),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y, mo, d, h, mi, s;
    logic       w;
  } fld_t;

  typedef struct packed {
    logic [47:0] ld;
    logic [47:0] exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  fld_t model;
  fld_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic fld_t dut_f();
    return {year, month, day, hour, minute, second, wrapped};
  endfunction

  // Reference: treat the calendar as one linear count of seconds
  function automatic fld_t model_next(input fld_t c, input logic dn);
    longint unsigned per, t;
    fld_t r;
    per = longint'(YM + 1) * MO * DPM * 86400;
    t = c.y;
    t = t * MO + c.mo;
    t = t * DPM + c.d;
    t = t * 24 + c.h;
    t = t * 60 + c.mi;
    t = t * 60 + c.s;
    r = c;
    if (!dn) begin
      t = t + 1;
      if (t == per) begin t = 0; r.w = 1'b1; end
    end else if (t == 0) begin
      t = per - 1;
      r.w = 1'b1;
    end else begin
      t = t - 1;
    end
    r.s  = 8'(t % 60);  t = t / 60;
    r.mi = 8'(t % 60);  t = t / 60;
    r.h  = 8'(t % 24);  t = t / 24;
    r.d  = 8'(t % DPM); t = t / DPM;
    r.mo = 8'(t % MO);  t = t / MO;
    r.y  = 8'(t);
    return r;
  endfunction

  task automatic do_load(input logic [7:0] y, mo, d, h, mi, s);
    {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} = {y, mo, d, h, mi, s};
    load = 1'b1;
    step();
    load = 1'b0;
    model = {y, mo, d, h, mi, s, 1'b0};
  endtask

  // Push the model's next value, then wait (bounded) for sec_tick and compare
  task automatic expect_tick(input int gap, input string name);
    fld_t e;
    bit   seen;
    int   cyc;
    model = model_next(model, dir);
    exp_q.push_back(model);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= gap + 2 && !seen; i++) begin
      step();
      if (sec_tick) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    e = exp_q.pop_front();
    check({name, " tick seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({name, " fields"}, 64'(dut_f()), 64'(e));
      check({name, " gap"}, 64'(cyc), 64'(gap));
    end
  endtask

  task automatic alarm_run(input logic [7:0] ls, output int pulses, output int on_time);
    logic       prev_tick;
    logic [7:0] prev_sec;
    {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} = {40'd0, ls};
    load  = 1'b1;
    start = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b0;
    pulses  = 0;
    on_time = 0;
    prev_tick = sec_tick;
    prev_sec  = second;
    repeat (20) begin
      step();
      if (alarm) begin
        pulses++;
        if (prev_tick && prev_sec == 8'd3) on_time++;
      end
      prev_tick = sec_tick;
      prev_sec  = second;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   pulses, on_time, ticks_seen;

    vecs[0] = '{{8'd99,  8'd11,  8'd29,  8'd23,  8'd59,  8'd59},
                {8'd99,  8'd11,  8'd29,  8'd23,  8'd59,  8'd59}};
    vecs[1] = '{{8'd200, 8'd12,  8'd30,  8'd24,  8'd60,  8'd60},
                {8'd99,  8'd11,  8'd29,  8'd23,  8'd59,  8'd59}};
    vecs[2] = '{{8'd5,   8'd3,   8'd7,   8'd30,  8'd10,  8'd75},
                {8'd5,   8'd3,   8'd7,   8'd23,  8'd10,  8'd59}};
    vecs[3] = '{{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0},
                {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0}};
    vecs[4] = '{{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
                {8'd99,  8'd11,  8'd29,  8'd23,  8'd59,  8'd59}};
    vecs[5] = '{{8'd100, 8'd11,  8'd15,  8'd12,  8'd59,  8'd61},
                {8'd99,  8'd11,  8'd15,  8'd12,  8'd59,  8'd59}};

    reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; dir = 1'b0;
    alarm_en = 1'b0; al_hour = 8'd0; al_minute = 8'd0; al_second = 8'd0;
    {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} = '0;
    step();
    step();
    check("reset fields", 64'(dut_f()), 64'(0));
    check("reset running", 64'(running), 64'(0));
    check("reset sec_tick", 64'(sec_tick), 64'(0));
    check("reset alarm", 64'(alarm), 64'(0));
    reset = 1'b0;

    // Table-driven preset loads while idle, including saturation
    for (int i = 0; i < 6; i++) begin
      {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} = vecs[i].ld;
      load = 1'b1;
      step();
      load = 1'b0;
      check($sformatf("load vec %0d", i),
            64'({year, month, day, hour, minute, second}), 64'(vecs[i].exp));
      check($sformatf("load vec %0d sec_tick", i), 64'(sec_tick), 64'(0));
    end

    // Start latency: first tick TD edges after the start edge
    do_load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start running", 64'(running), 64'(1));
    expect_tick(TD, "first tick");
    expect_tick(TD, "second tick");

    // Full cascade up with year wrap
    do_load(8'd99, 8'd11, 8'd29, 8'd23, 8'd59, 8'd59);
    expect_tick(TD, "wrap up");
    step();
    check("wrap up single tick", 64'(sec_tick), 64'(0));

    // Full borrow down with year wrap
    dir = 1'b1;
    do_load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    check("load clears wrapped", 64'(wrapped), 64'(0));
    expect_tick(TD, "wrap down");
    dir = 1'b0;

    // Stop after two prescaler counts, hold 5 cycles, resume
    do_load(8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3);
    step();
    stop = 1'b1;
    step();
    check("stop running", 64'(running), 64'(0));
    ticks_seen = 0;
    repeat (4) begin
      step();
      if (sec_tick) ticks_seen++;
    end
    stop = 1'b0;
    check("stopped no tick", 64'(ticks_seen), 64'(0));
    check("stopped fields", 64'(dut_f()), 64'(model));
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume running", 64'(running), 64'(1));
    expect_tick(2, "resume tick");
    start = 1'b1;
    stop  = 1'b1;
    step();
    check("start+stop idle", 64'(running), 64'(0));
    start = 1'b0;
    stop  = 1'b0;

    // Alarm at 00:00:03
    al_hour = 8'd0; al_minute = 8'd0; al_second = 8'd3;
    alarm_en = 1'b1;
    alarm_run(8'd0, pulses, on_time);
    check("alarm pulses", 64'(pulses), 64'(1));
    check("alarm timing", 64'(on_time), 64'(1));
    alarm_en = 1'b0;
    alarm_run(8'd0, pulses, on_time);
    check("alarm disabled", 64'(pulses), 64'(0));
    alarm_en = 1'b1;
    alarm_run(8'd3, pulses, on_time);
    check("alarm on load", 64'(pulses), 64'(0));
    alarm_en = 1'b0;

    // Load coincident with a tick
    start = 1'b1;
    do_load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    start = 1'b0;
    repeat (3) step();
    do_load(8'd10, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    check("coincident load fields", 64'(dut_f()), 64'(model));
    check("coincident load no tick", 64'(sec_tick), 64'(0));
    expect_tick(TD, "after load");

    // Reset with an alarm pending after a full cascade
    al_hour = 8'd0; al_minute = 8'd0; al_second = 8'd0;
    alarm_en = 1'b1;
    do_load(8'd99, 8'd11, 8'd29, 8'd23, 8'd59, 8'd59);
    expect_tick(TD, "cascade");
    reset = 1'b1;
    step();
    check("reset pending alarm", 64'(alarm), 64'(0));
    check("reset mid fields", 64'(dut_f()), 64'(0));
    check("reset mid running", 64'(running), 64'(0));
    reset = 1'b0;

    // Reset landing on the cascade tick edge
    start = 1'b1;
    do_load(8'd99, 8'd11, 8'd29, 8'd23, 8'd59, 8'd59);
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("reset on tick fields", 64'(dut_f()), 64'(0));
    check("reset on tick sec_tick", 64'(sec_tick), 64'(0));
    check("reset on tick running", 64'(running), 64'(0));
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
